squarer_ckt: RTL and testbench
==============================

SQUARER_CKT -- requirements
Module: squarer_ckt

Interface
REQ-001 Parameters: none; the 3-bit input and 6-bit output widths are fixed.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 a0  input  1  operand bit 0 (LSB).
REQ-006 a1  input  1  operand bit 1.
REQ-007 a2  input  1  operand bit 2 (MSB).
REQ-008 in_valid  input  1  operand {a2,a1,a0} is valid this cycle.
REQ-009 y0  output  1  square bit 0 (LSB).
REQ-010 y1  output  1  square bit 1.
REQ-011 y2  output  1  square bit 2.
REQ-012 y3  output  1  square bit 3.
REQ-013 y4  output  1  square bit 4.
REQ-014 y5  output  1  square bit 5 (MSB).
REQ-015 out_valid  output  1  {y5..y0} holds a valid square this cycle.
REQ-016 Positional port order SHALL be y0,y1,y2,y3,y4,y5,a0,a1,a2,clk,rst,in_valid,out_valid.

Function
REQ-017 Operand A = {a2,a1,a0} is unsigned, range 0..7; result Y = {y5,y4,y3,y2,y1,y0} = A*A, unsigned, range 0..49; no overflow is possible.
REQ-018 Latency SHALL be exactly 1 cycle: when in_valid=1 at rising edge N, Y = A^2 and out_valid=1 after edge N.
REQ-019 When in_valid=0 at an edge, out_valid SHALL go 0 and Y SHALL hold its previous value.
REQ-020 Back-to-back valid operands SHALL be accepted every cycle; there is no backpressure and no stall.
REQ-021 The core SHALL be pure sum-of-products logic with no multiplier operator: y0=a0; y1=0; y2=a1&~a0; y3=a0&(a1^a2); y4=a2&(~a1|a0); y5=a2&a1.
REQ-022 y1 SHALL be constant 0 for every input value.

Reset
REQ-023 When rst=1 at an edge, Y SHALL be 0 and out_valid SHALL be 0 after that edge, regardless of in_valid.
REQ-024 Reset SHALL take priority over a simultaneous valid operand; that operand is dropped.
REQ-025 On the first edge with rst=0, normal operation resumes with 1-cycle latency.

Configuration
REQ-026 Macro SQUARER_CKT_PARITY_EN defined: extra output y_par (1 bit, last positional port) SHALL be the registered XOR of y0..y5, updated with Y, reset to 0.
REQ-027 Macro SQUARER_CKT_PARITY_EN undefined: y_par SHALL NOT exist; all other behaviour is identical.

Structure
REQ-028 Package squarer_pkg SHALL hold the constants SQ_IN_W=3, SQ_OUT_W=6 and SQ_MAX_RESULT=49.
REQ-029 Combinational equations SHALL reside in sub-module squarer_core (inputs a0..a2, outputs y0..y5); squarer_ckt wraps it with the output and valid registers.

Verification
REQ-030 Exhaustive sweep: A=0..7, one per cycle with in_valid=1 -> Y=0,1,4,9,16,25,36,49, each 1 cycle later, with out_valid=1.
REQ-031 Reset: rst=1 with A=7 and in_valid=1 -> after the edge Y=0 and out_valid=0; after rst is released, A=5 -> Y=25 next cycle.
REQ-032 Hold: A=6 valid, then in_valid=0 with A=3 -> Y stays 36 and out_valid=0.
REQ-033 Invariant: for all A, y1=0 and y0=a0 of the operand sampled the previous cycle.
REQ-034 Parity (macro defined): A=7 -> Y=49 (110001), y_par=1; A=3 -> Y=9 (001001), y_par=0.

Source files
------------

// File: rtl/squarer_pkg.sv
// Shared constants for the 3-bit squarer.
package squarer_pkg;
  localparam int SQ_IN_W       = 3;
  localparam int SQ_OUT_W      = 6;
  localparam int SQ_MAX_RESULT = 49;
endpackage

// File: rtl/squarer_ckt_if.sv
// Operand/result bundle for the squarer; master drives operands, slave returns squares.
interface squarer_ckt_if;
  import squarer_pkg::*;
  logic [SQ_IN_W-1:0]  a;
  logic                in_valid;
  logic [SQ_OUT_W-1:0] y;
  logic                out_valid;
  logic                y_par;

  modport master (output a, output in_valid, input y, input out_valid, input y_par);
  modport slave  (input a, input in_valid, output y, output out_valid, output y_par);
endinterface

// File: rtl/squarer_core.sv
// Combinational sum-of-products square of a 3-bit unsigned operand.
module squarer_core (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3,
  output logic y4,
  output logic y5
);
  // Bit 1 of any square is always zero, so it is tied off.
  assign y0 = a0;
  assign y1 = 1'b0;
  assign y2 = a1 & ~a0;
  assign y3 = a0 & (a1 ^ a2);
  assign y4 = a2 & (~a1 | a0);
  assign y5 = a2 & a1;
endmodule

// File: rtl/squarer_ckt.sv
// Registered 3-bit squarer with 1-cycle latency; SQUARER_CKT_PARITY_EN adds a y_par output.
module squarer_ckt
  import squarer_pkg::*;
(
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3,
  output logic y4,
  output logic y5,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
`ifdef SQUARER_CKT_PARITY_EN
  , output logic y_par
`endif
);
  logic [SQ_OUT_W-1:0] sq;
  logic [SQ_OUT_W-1:0] y_d, y_q;
  logic                vld_d, vld_q;

  squarer_core u_core (
    .a0(a0), .a1(a1), .a2(a2),
    .y0(sq[0]), .y1(sq[1]), .y2(sq[2]), .y3(sq[3]), .y4(sq[4]), .y5(sq[5])
  );

  // Result holds when no operand is presented.
  assign y_d   = in_valid ? sq : y_q;
  assign vld_d = in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign {y5, y4, y3, y2, y1, y0} = y_q;
  assign out_valid = vld_q;

`ifdef SQUARER_CKT_PARITY_EN
  logic par_d, par_q;
  assign par_d = ^y_d;

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign y_par = par_q;
`endif
endmodule

// File: tb/tb_squarer_ckt.sv
// Self-checking bench for squarer_ckt against an arithmetic reference model.
module tb_squarer_ckt;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  squarer_ckt_if bus ();
  logic y0, y1, y2, y3, y4, y5, ov;
`ifdef SQUARER_CKT_PARITY_EN
  logic par;
  assign bus.y_par = par;
`else
  assign bus.y_par = 1'b0;
`endif
  assign bus.y = {y5, y4, y3, y2, y1, y0};
  assign bus.out_valid = ov;

  squarer_ckt dut (
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
    .a0(bus.a[0]), .a1(bus.a[1]), .a2(bus.a[2]),
    .clk(clk), .rst(rst), .in_valid(bus.in_valid), .out_valid(ov)
`ifdef SQUARER_CKT_PARITY_EN
    , .y_par(par)
`endif
  );

  int errs   = 0;
  int checks = 0;
  int exp_y  = 0;
  bit exp_v  = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step(input int a, input bit v, input bit r, input string tag);
    @(negedge clk);
    bus.a        = a[2:0];
    bus.in_valid = v;
    rst          = r;
    @(posedge clk);
    if (r) begin
      exp_y = 0;
      exp_v = 1'b0;
    end else if (v) begin
      exp_y = a * a;
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    #1;
    chk({tag, ".y"}, int'(bus.y), exp_y);
    chk({tag, ".vld"}, int'(bus.out_valid), int'(exp_v));
    chk({tag, ".y1"}, int'(y1), 0);
    chk({tag, ".y0"}, int'(y0), exp_y % 2);
`ifdef SQUARER_CKT_PARITY_EN
    chk({tag, ".par"}, int'(bus.y_par), $countones(exp_y) % 2);
`endif
  endtask

  initial begin
    bus.a        = 3'd0;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    step(0, 1'b0, 1'b1, "rst0");
    step(3, 1'b1, 1'b1, "rst1");

    for (int i = 0; i < 8; i++) step(i, 1'b1, 1'b0, "sweep");

    step(7, 1'b1, 1'b1, "rst_prio");
    step(5, 1'b1, 1'b0, "rst_rel");

    step(6, 1'b1, 1'b0, "hold_a");
    step(3, 1'b0, 1'b0, "hold_b");
    step(1, 1'b0, 1'b0, "hold_c");

    step(7, 1'b1, 1'b0, "par7");
    step(3, 1'b1, 1'b0, "par3");

    for (int i = 0; i < 60; i++) begin
      int a;
      bit v, r;
      a = int'($urandom_range(0, 7));
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 15) == 0);
      step(a, v, r, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
